// File: rtl/gpr_scoreboard_file.sv
// gpr_scoreboard_file: GPR array with a one-bit-per-register write scoreboard.
// Holds a decoded request until its sources and destination are free, then
// presents registered operands to EXU. WBU retires writes in any state.
// Optional macro GPR_BYPASS_EN: forward same-cycle WBU data into operand capture.
module gpr_scoreboard_file #(
    parameter int XLEN    = 32,
    parameter int NR_REGS = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               idu_valid,
    output logic               idu_ready,
    input  logic [4:0]         idu_rs1,
    input  logic [4:0]         idu_rs2,
    input  logic [4:0]         idu_rd,
    input  logic               idu_rd_wen,
    output logic               exu_valid,
    input  logic               exu_ready,
    output logic [XLEN-1:0]    exu_src1,
    output logic [XLEN-1:0]    exu_src2,
    input  logic               wbu_valid,
    output logic               wbu_ready,
    input  logic [4:0]         wbu_rd,
    input  logic               wbu_wen,
    input  logic [XLEN-1:0]    wbu_wdata,
    output logic [NR_REGS-1:0] busy_vec
);

    localparam int IW = $clog2(NR_REGS);

    typedef enum logic [1:0] {IDLE, WAIT, SEND} state_t;

    state_t             state, state_next;
    logic [XLEN-1:0]    regs [NR_REGS];
    logic [NR_REGS-1:0] busy;
    logic [4:0]         rs1_q, rs2_q, rd_q;
    logic               rd_wen_q;
    logic [XLEN-1:0]    src1_q, src2_q;

    logic               wb_we, issue, hazard;
    logic               rs1_ok, rs2_ok, rd_ok;
    logic               hit1, hit2, hitd;
    logic [XLEN-1:0]    op1, op2;

    // Index is architecturally valid: nonzero and within the configured count.
    function automatic logic idx_ok(input logic [4:0] i);
        return (i != 5'd0) && ({27'd0, i} < 32'(NR_REGS));
    endfunction

    // Hazard detection and operand selection for the latched request.
    always_comb begin
        wb_we  = wbu_valid && wbu_wen && idx_ok(wbu_rd);
        rs1_ok = idx_ok(rs1_q);
        rs2_ok = idx_ok(rs2_q);
        rd_ok  = idx_ok(rd_q);
`ifdef GPR_BYPASS_EN
        hit1 = wb_we && (wbu_rd == rs1_q);
        hit2 = wb_we && (wbu_rd == rs2_q);
        hitd = wb_we && (wbu_rd == rd_q);
`else
        hit1 = 1'b0;
        hit2 = 1'b0;
        hitd = 1'b0;
`endif
        hazard = (rs1_ok && busy[rs1_q[IW-1:0]] && !hit1)
              || (rs2_ok && busy[rs2_q[IW-1:0]] && !hit2)
              || (rd_wen_q && rd_ok && busy[rd_q[IW-1:0]] && !hitd);
        op1 = !rs1_ok ? '0 : (hit1 ? wbu_wdata : regs[rs1_q[IW-1:0]]);
        op2 = !rs2_ok ? '0 : (hit2 ? wbu_wdata : regs[rs2_q[IW-1:0]]);
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_next = state;
        idu_ready  = 1'b0;
        exu_valid  = 1'b0;
        issue      = 1'b0;
        unique case (state)
            IDLE: begin
                idu_ready = 1'b1;
                if (idu_valid) state_next = WAIT;
            end
            WAIT: begin
                if (!hazard) begin
                    issue      = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                exu_valid = 1'b1;
                if (exu_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Request latch on accept and operand capture on issue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs1_q    <= '0;
            rs2_q    <= '0;
            rd_q     <= '0;
            rd_wen_q <= 1'b0;
            src1_q   <= '0;
            src2_q   <= '0;
        end else begin
            if (state == IDLE && idu_valid) begin
                rs1_q    <= idu_rs1;
                rs2_q    <= idu_rs2;
                rd_q     <= idu_rd;
                rd_wen_q <= idu_rd_wen;
            end
            if (issue) begin
                src1_q <= op1;
                src2_q <= op2;
            end
        end
    end

    // Register array write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NR_REGS; i++) regs[i] <= '0;
        end else if (wb_we) begin
            regs[wbu_rd[IW-1:0]] <= wbu_wdata;
        end
    end

    // Scoreboard: the issue set is ordered after the write-back clear so set wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            if (wb_we) busy[wbu_rd[IW-1:0]] <= 1'b0;
            if (issue && rd_wen_q && rd_ok) busy[rd_q[IW-1:0]] <= 1'b1;
        end
    end

    assign exu_src1  = src1_q;
    assign exu_src2  = src2_q;
    assign wbu_ready = 1'b1;
    assign busy_vec  = busy;

endmodule

// File: tb/tb_gpr_scoreboard_file.sv
// Bench for gpr_scoreboard_file: directed scenarios followed by random traffic,
// all compared every cycle against a behavioural register/scoreboard model.
module tb_gpr_scoreboard_file;

    localparam int XLEN    = 32;
    localparam int NR_REGS = 16;
`ifdef GPR_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               idu_valid, idu_ready, idu_rd_wen;
    logic [4:0]         idu_rs1, idu_rs2, idu_rd;
    logic               exu_valid, exu_ready;
    logic [XLEN-1:0]    exu_src1, exu_src2;
    logic               wbu_valid, wbu_ready, wbu_wen;
    logic [4:0]         wbu_rd;
    logic [XLEN-1:0]    wbu_wdata;
    logic [NR_REGS-1:0] busy_vec;

    always #5 clk = ~clk;

    gpr_scoreboard_file #(.XLEN(XLEN), .NR_REGS(NR_REGS)) dut (
        .clk(clk), .rst(rst),
        .idu_valid(idu_valid), .idu_ready(idu_ready),
        .idu_rs1(idu_rs1), .idu_rs2(idu_rs2), .idu_rd(idu_rd), .idu_rd_wen(idu_rd_wen),
        .exu_valid(exu_valid), .exu_ready(exu_ready),
        .exu_src1(exu_src1), .exu_src2(exu_src2),
        .wbu_valid(wbu_valid), .wbu_ready(wbu_ready),
        .wbu_rd(wbu_rd), .wbu_wen(wbu_wen), .wbu_wdata(wbu_wdata),
        .busy_vec(busy_vec)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: architectural registers, pending-write flags,
    // the held request and whether operands are waiting for EXU.
    logic [XLEN-1:0] m_regs [32];
    bit              m_busy [32];
    bit              m_held, m_ops;
    logic [4:0]      m_rs1, m_rs2, m_rd;
    bit              m_wen;
    logic [XLEN-1:0] m_src1, m_src2;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit ok(input logic [4:0] i);
        return (i != 5'd0) && (int'(i) < NR_REGS);
    endfunction

    function automatic logic [XLEN-1:0] operand(input logic [4:0] i, input bit wb);
        if (!ok(i)) return '0;
        if (BYP && wb && wbu_rd == i) return wbu_wdata;
        return m_regs[i];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
        m_held = 0; m_ops = 0;
        m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_wen = 0;
        m_src1 = '0; m_src2 = '0;
    endtask

    // Advance the model across one rising edge using the current inputs.
    task automatic model_edge();
        bit wb, issue, h1, h2, hd, res;
        wb    = wbu_valid && wbu_wen && ok(wbu_rd);
        issue = 0;
        if (m_ops) begin
            if (exu_ready) m_ops = 0;
        end else if (m_held) begin
            res = BYP && wb;
            h1 = ok(m_rs1) && m_busy[m_rs1] && !(res && wbu_rd == m_rs1);
            h2 = ok(m_rs2) && m_busy[m_rs2] && !(res && wbu_rd == m_rs2);
            hd = m_wen && ok(m_rd) && m_busy[m_rd] && !(res && wbu_rd == m_rd);
            if (!(h1 || h2 || hd)) begin
                m_src1 = operand(m_rs1, wb);
                m_src2 = operand(m_rs2, wb);
                issue  = 1;
                m_held = 0;
                m_ops  = 1;
            end
        end else if (idu_valid) begin
            m_rs1 = idu_rs1; m_rs2 = idu_rs2; m_rd = idu_rd; m_wen = idu_rd_wen;
            m_held = 1;
        end
        if (wb) begin
            m_regs[wbu_rd] = wbu_wdata;
            m_busy[wbu_rd] = 1'b0;
        end
        if (issue && m_wen && ok(m_rd)) m_busy[m_rd] = 1'b1;
    endtask

    task automatic compare_all();
        logic [NR_REGS-1:0] e;
        for (int i = 0; i < NR_REGS; i++) e[i] = m_busy[i];
        check("idu_ready", idu_ready, !m_held && !m_ops);
        check("exu_valid", exu_valid, m_ops);
        check("busy_vec",  busy_vec, e);
        check("exu_src1",  exu_src1, m_src1);
        check("exu_src2",  exu_src2, m_src2);
        check("wbu_ready", wbu_ready, 1'b1);
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic quiet();
        idu_valid = 0; idu_rs1 = '0; idu_rs2 = '0; idu_rd = '0; idu_rd_wen = 0;
        exu_ready = 0;
        wbu_valid = 0; wbu_wen = 0; wbu_rd = '0; wbu_wdata = '0;
    endtask

    task automatic request(input logic [4:0] r1, input logic [4:0] r2,
                           input logic [4:0] rd, input bit wen);
        idu_valid = 1; idu_rs1 = r1; idu_rs2 = r2; idu_rd = rd; idu_rd_wen = wen;
        tick();
        idu_valid = 0;
    endtask

    task automatic write_back(input logic [4:0] rd, input logic [XLEN-1:0] d);
        wbu_valid = 1; wbu_wen = 1; wbu_rd = rd; wbu_wdata = d;
    endtask

    task automatic drain();
        exu_ready = 1;
        tick();
        exu_ready = 0;
    endtask

    initial begin
        quiet();
        model_reset();
        rst = 1;
        #12;
        compare_all();
        check("rst_idu_ready", idu_ready, 1'b1);
        check("rst_busy", busy_vec, '0);
        rst = 0;

        // Basic read of a written register: valid two cycles after accept.
        write_back(5'd5, 32'h12345678);
        tick();
        quiet();
        request(5'd5, 5'd0, 5'd0, 0);
        check("t1_wait", exu_valid, 1'b0);
        tick();
        check("t1_valid", exu_valid, 1'b1);
        check("t1_src1", exu_src1, 32'h12345678);
        check("t1_src2", exu_src2, 32'h0);
        drain();

        // RAW stall on x7 until write-back.
        request(5'd0, 5'd0, 5'd7, 1);
        tick();
        check("t2_busy7", busy_vec[7], 1'b1);
        drain();
        request(5'd7, 5'd0, 5'd0, 0);
        tick();
        tick();
        check("t2_stall", exu_valid, 1'b0);
        check("t2_busy7b", busy_vec[7], 1'b1);
        write_back(5'd7, 32'hA5A5A5A5);
        tick();
        quiet();
        check("t2_early", exu_valid, BYP);
        if (!exu_valid) tick();
        check("t2_valid", exu_valid, 1'b1);
        check("t2_src1", exu_src1, 32'hA5A5A5A5);
        drain();

        // Out-of-range index is inert.
        write_back(5'd20, 32'hFFFFFFFF);
        tick();
        quiet();
        check("t3_busy", busy_vec, '0);
        request(5'd20, 5'd20, 5'd0, 0);
        tick();
        check("t3_src1", exu_src1, 32'h0);
        check("t3_src2", exu_src2, 32'h0);
        drain();

        // x0 is hardwired zero and never scoreboarded.
        write_back(5'd0, 32'hDEADBEEF);
        tick();
        quiet();
        request(5'd0, 5'd0, 5'd0, 1);
        tick();
        check("t4_src1", exu_src1, 32'h0);
        check("t4_busy", busy_vec, '0);
        drain();

        // Back-pressure in SEND holds everything stable.
        request(5'd5, 5'd7, 5'd0, 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t5_valid", exu_valid, 1'b1);
            check("t5_src1", exu_src1, 32'h12345678);
            check("t5_src2", exu_src2, 32'hA5A5A5A5);
            check("t5_idu_ready", idu_ready, 1'b0);
        end
        drain();
        check("t5_idle", idu_ready, 1'b1);
        check("t5_drop", exu_valid, 1'b0);

        // Same-edge issue set and write-back clear on x3: set wins.
        request(5'd0, 5'd0, 5'd3, 1);
        write_back(5'd3, 32'h33333333);
        tick();
        quiet();
        check("t6_busy3", busy_vec[3], 1'b1);
        drain();

        // Reset pulse while stalled in WAIT.
        request(5'd3, 5'd0, 5'd0, 0);
        tick();
        check("t6_stall", exu_valid, 1'b0);
        #3;
        rst = 1;
        #1;
        model_reset();
        check("t6_rst_idu_ready", idu_ready, 1'b1);
        check("t6_rst_exu_valid", exu_valid, 1'b0);
        check("t6_rst_busy", busy_vec, '0);
        check("t6_rst_src1", exu_src1, 32'h0);
        check("t6_rst_src2", exu_src2, 32'h0);
        @(posedge clk);
        #1;
        rst = 0;
        compare_all();
        request(5'd5, 5'd3, 5'd0, 0);
        tick();
        check("t6_cleared", exu_src1, 32'h0);
        drain();

        // Random traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            idu_valid  = ($urandom_range(0, 1) == 1);
            idu_rs1    = 5'($urandom_range(0, NR_REGS + 3));
            idu_rs2    = 5'($urandom_range(0, NR_REGS + 3));
            idu_rd     = 5'($urandom_range(0, NR_REGS + 3));
            idu_rd_wen = ($urandom_range(0, 2) != 0);
            exu_ready  = ($urandom_range(0, 1) == 1);
            wbu_valid  = ($urandom_range(0, 4) < 2);
            wbu_wen    = ($urandom_range(0, 4) != 0);
            wbu_rd     = 5'($urandom_range(0, NR_REGS + 3));
            wbu_wdata  = $urandom;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpr_scoreboard_file.md
# gpr_scoreboard_file

Parametrised general-purpose register file with per-register scoreboard, sitting between IDU, EXU and WBU. It accepts decoded operand requests from IDU, holds an issue until neither source nor destination register has an outstanding write, then delivers registered operands to EXU over a valid/ready handshake. WBU writes retire into the array and clear scoreboard bits. It supports RV32E (16) or RV32I (32) register counts and optional write-to-read forwarding.

## Interface
Parameters:
- XLEN, 32, register data width
- NR_REGS, 16, number of architectural registers (16 or 32); index field is always 5 bits

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- idu_valid  in  1  operand request valid
- idu_ready  out  1  block can accept a request
- idu_rs1  in  5  source 1 index
- idu_rs2  in  5  source 2 index
- idu_rd  in  5  destination index
- idu_rd_wen  in  1  instruction will write rd
- exu_valid  out  1  operands valid
- exu_ready  in  1  EXU accepts operands
- exu_src1  out  XLEN  operand 1
- exu_src2  out  XLEN  operand 2
- wbu_valid  in  1  write-back valid
- wbu_ready  out  1  constant 1, write-back always accepted
- wbu_rd  in  5  write index
- wbu_wen  in  1  write enable
- wbu_wdata  in  XLEN  write data
- busy_vec  out  NR_REGS  scoreboard bits, bit i = register i has pending write

## Operation
- Register index "valid" means 0 < idx < NR_REGS. Reads of invalid indices return 0; writes to them are dropped and never touch the scoreboard.
- FSM states IDLE, WAIT, SEND.
- IDLE: idu_ready=1. idu_valid latches rs1, rs2, rd, rd_wen; next WAIT. Otherwise stay.
- WAIT: idu_ready=0. Hazard if busy[rs1] or busy[rs2] or (rd_wen and busy[rd]) for valid indices. On hazard stay WAIT. Without hazard: capture operands into exu_src1/2, set busy[rd] if rd_wen and rd valid; next SEND.
- SEND: exu_valid=1, operands held stable. exu_ready -> IDLE. exu_valid never drops without acceptance.
- Write-back: wbu_valid & wbu_wen & valid wbu_rd writes regs[wbu_rd] and clears busy[wbu_rd] at the edge, in any state.
- Simultaneous set (WAIT issue) and clear (WBU) on same bit: set wins; register data still written.
- WAW: one-bit scoreboard allows one outstanding writer per register; enforced by rd hazard check.
- Arithmetic: none; all data paths are XLEN bits, indices compared as 5-bit unsigned.

## Timing
- Reset: all regs 0, busy_vec 0, state IDLE, idu_ready 1, exu_valid 0, exu_src1/2 0, wbu_ready 1.
- Reset asserted mid-operation: returns to reset values immediately; in-flight request and pending bits discarded.
- No hazard: request accepted cycle 0, operands captured end of cycle 1, exu_valid high cycle 2. Minimum 3 cycles between successive accepts.
- Hazard: WAIT re-evaluated each cycle; without forwarding, capture occurs the cycle after the clearing write-back.
- busy_vec and array are registered; combinational reads in WAIT see pre-edge values.

## Configuration
- GPR_BYPASS_EN defined: in WAIT, a busy source whose register is being written by WBU this same cycle counts as resolved and takes wbu_wdata directly; capture one cycle earlier. rd hazard likewise resolved by a same-cycle clear.
- Undefined: no forwarding; hazard persists until busy bit clear at edge, operands read from array.

## Test plan
- Reset then WBU writes x5=0x12345678; request rs1=5, rs2=0 -> exu_valid on cycle 2 after accept, src1=0x12345678, src2=0.
- Request rd=7 rd_wen=1, accept; second request rs1=7 -> stalls in WAIT, busy_vec[7]=1 until WBU writes x7=0xA5A5A5A5; src1=0xA5A5A5A5, one cycle later without GPR_BYPASS_EN than with.
- NR_REGS=16: WBU write x20=0xFFFFFFFF, request rs1=20 -> src1=0, busy_vec unchanged.
- Write x0=0xDEADBEEF, rd=0 rd_wen=1 request -> x0 reads 0, busy_vec stays 0.
- Hold exu_ready=0 for 5 cycles in SEND -> exu_valid and src1/src2 stable, idu_ready=0; release -> IDLE next cycle.
- Same-cycle issue setting busy[3] and WBU clearing busy[3] -> busy_vec[3]=1 after edge, x3 holds new data; rst pulse mid-WAIT -> all outputs at reset values.
